// File: rtl/primus_core_pkg.sv
// Shared types and constants for the primus core front end.
package primus_core_pkg;

  localparam logic [31:0] NOP_INSTR        = 32'h0000_0013;
  localparam logic [31:0] RESET_PC_DEFAULT = 32'h0000_0000;

  typedef struct packed {
    logic [31:0] pc;
    logic [31:0] instr;
  } fetch_entry_t;

endpackage

// File: rtl/if_stage_fetch_fifo.sv
// Fetch buffer: synchronous FIFO of fetch entries with flush; the head is read
// combinationally from registered storage.
module fetch_fifo
  import primus_core_pkg::*;
#(
  parameter int DEPTH = 4,
  localparam int AW = $clog2(DEPTH),
  localparam int CW = AW + 1
) (
  input  logic         clk_i,
  input  logic         rst_i,
  input  logic         push_i,
  input  fetch_entry_t push_entry_i,
  input  logic         pop_i,
  input  logic         flush_i,
  output logic [CW-1:0] occ_o,
  output fetch_entry_t head_o
);

  fetch_entry_t mem_q [DEPTH];
  logic [AW-1:0] rd_q, rd_d, wr_q, wr_d;
  logic [CW-1:0] occ_q, occ_d;
  logic full, empty, do_push, do_pop;

  assign full    = (occ_q == CW'(DEPTH));
  assign empty   = (occ_q == '0);
  // A push into a full buffer is only legal when the head leaves the same cycle.
  assign do_push = push_i && !flush_i && (!full || pop_i);
  assign do_pop  = pop_i && !flush_i && !empty;

  always_comb begin
    rd_d  = rd_q;
    wr_d  = wr_q;
    occ_d = occ_q;
    if (flush_i) begin
      rd_d  = '0;
      wr_d  = '0;
      occ_d = '0;
    end else begin
      if (do_push) wr_d = wr_q + AW'(1);
      if (do_pop)  rd_d = rd_q + AW'(1);
      occ_d = occ_q + CW'(do_push) - CW'(do_pop);
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      rd_q  <= '0;
      wr_q  <= '0;
      occ_q <= '0;
    end else begin
      rd_q  <= rd_d;
      wr_q  <= wr_d;
      occ_q <= occ_d;
    end
  end

  always_ff @(posedge clk_i) begin
    if (!rst_i && do_push) mem_q[wr_q] <= push_entry_i;
  end

  assign occ_o  = occ_q;
  assign head_o = mem_q[rd_q];

endmodule

// File: rtl/if_stage.sv
// Instruction-fetch stage: PC, credit-limited request issue, stale-response
// dropping after redirects, and the fetch buffer feeding ID.
module if_stage
  import primus_core_pkg::*;
#(
  parameter logic [31:0] RESET_PC   = RESET_PC_DEFAULT,
  parameter int          FIFO_DEPTH = 4
) (
  input  logic        clk_i,
  input  logic        rst_i,
  output logic        imem_req_o,
  output logic [31:0] imem_addr_o,
  input  logic        imem_gnt_i,
  input  logic        imem_rvalid_i,
  input  logic [31:0] imem_rdata_i,
  input  logic        redirect_i,
  input  logic [31:0] redirect_pc_i,
  input  logic        stall_i,
  output logic        if_valid_o,
  output logic [31:0] instr_o,
  output logic [31:0] pc_o,
  output logic [31:0] npc_o
);

  localparam int CW = $clog2(FIFO_DEPTH) + 1;

  logic [31:0]   fetch_pc_q, fetch_pc_d, rsp_pc_q, rsp_pc_d;
  logic [CW-1:0] inflight_q, inflight_d, drop_q, drop_d, occ;
  logic [CW:0]   used;
  logic          fire, rv, push, pop;
  fetch_entry_t  head, push_entry;

  assign used        = (CW+1)'(occ) + (CW+1)'(inflight_q);
  assign imem_req_o  = !rst_i && !redirect_i && (used < (CW+1)'(FIFO_DEPTH));
  assign imem_addr_o = fetch_pc_q;
  assign fire        = imem_req_o && imem_gnt_i;
  assign rv          = imem_rvalid_i && (inflight_q != '0);
  assign if_valid_o  = (occ != '0);
  assign push_entry  = '{pc: rsp_pc_q, instr: imem_rdata_i};

  always_comb begin
    fetch_pc_d = fetch_pc_q;
    rsp_pc_d   = rsp_pc_q;
    inflight_d = inflight_q + CW'(fire) - CW'(rv);
    drop_d     = drop_q;
    push       = 1'b0;
    pop        = 1'b0;
    if (redirect_i) begin
      fetch_pc_d = redirect_pc_i & 32'hFFFF_FFFC;
      rsp_pc_d   = redirect_pc_i & 32'hFFFF_FFFC;
      // Every request still outstanding after this cycle belongs to the old
      // path, including any already marked for dropping.
      drop_d     = inflight_q - CW'(rv);
    end else begin
      if (fire) fetch_pc_d = fetch_pc_q + 32'd4;
      if (rv) begin
        if (drop_q != '0) begin
          drop_d = drop_q - CW'(1);
        end else begin
          push     = 1'b1;
          rsp_pc_d = rsp_pc_q + 32'd4;
        end
      end
      pop = if_valid_o && !stall_i;
    end
  end

  always_ff @(posedge clk_i) begin
    if (rst_i) begin
      fetch_pc_q <= RESET_PC;
      rsp_pc_q   <= RESET_PC;
      inflight_q <= '0;
      drop_q     <= '0;
    end else begin
      fetch_pc_q <= fetch_pc_d;
      rsp_pc_q   <= rsp_pc_d;
      inflight_q <= inflight_d;
      drop_q     <= drop_d;
    end
  end

  fetch_fifo #(.DEPTH(FIFO_DEPTH)) u_fifo (
    .clk_i       (clk_i),
    .rst_i       (rst_i),
    .push_i      (push),
    .push_entry_i(push_entry),
    .pop_i       (pop),
    .flush_i     (redirect_i),
    .occ_o       (occ),
    .head_o      (head)
  );

  // With nothing buffered, pc_o shows the PC the next instruction will carry.
  assign instr_o = if_valid_o ? head.instr : NOP_INSTR;
  assign pc_o    = if_valid_o ? head.pc : rsp_pc_q;
  assign npc_o   = pc_o + 32'd4;

endmodule

// File: tb/tb_if_stage.sv
// Self-checking bench for if_stage: a hand-computed vector table, directed
// corner sequences and a randomized run against a queue-based reference model.
module tb_if_stage;
  import primus_core_pkg::*;

  logic        clk = 1'b0;
  logic        rst_i, imem_req_o, imem_gnt_i, imem_rvalid_i, redirect_i, stall_i, if_valid_o;
  logic [31:0] imem_addr_o, imem_rdata_i, redirect_pc_i, instr_o, pc_o, npc_o;

  always #5 clk = ~clk;

  if_stage #(.RESET_PC(32'h0), .FIFO_DEPTH(4)) dut (
    .clk_i(clk), .rst_i(rst_i),
    .imem_req_o(imem_req_o), .imem_addr_o(imem_addr_o), .imem_gnt_i(imem_gnt_i),
    .imem_rvalid_i(imem_rvalid_i), .imem_rdata_i(imem_rdata_i),
    .redirect_i(redirect_i), .redirect_pc_i(redirect_pc_i), .stall_i(stall_i),
    .if_valid_o(if_valid_o), .instr_o(instr_o), .pc_o(pc_o), .npc_o(npc_o)
  );

  int total = 0;
  int bad   = 0;
  int cyc   = 0;
  int lat   = 1;

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %h expected %h (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  // Reference model: buffered entries, one stale flag per outstanding request.
  typedef struct { logic [31:0] pc; logic [31:0] instr; } ent_t;
  typedef struct { int due; logic [31:0] data; } rsp_t;
  ent_t        m_fifo[$];
  bit          m_out[$];
  rsp_t        mem_q[$];
  logic [31:0] m_fetch, m_rsp;

  typedef struct {
    logic gnt; logic rv; logic [31:0] rdata; logic redir; logic [31:0] tgt; logic stall;
    logic e_req; logic [31:0] e_addr; logic e_valid; logic [31:0] e_pc;
  } vec_t;

  function automatic vec_t mk(input logic g, input logic r, input logic [31:0] d,
                              input logic rd, input logic [31:0] t, input logic s,
                              input logic er, input logic [31:0] ea,
                              input logic ev, input logic [31:0] ep);
    vec_t v;
    v.gnt = g; v.rv = r; v.rdata = d; v.redir = rd; v.tgt = t; v.stall = s;
    v.e_req = er; v.e_addr = ea; v.e_valid = ev; v.e_pc = ep;
    return v;
  endfunction

  task automatic do_reset();
    rst_i = 1'b1; imem_gnt_i = 1'b0; imem_rvalid_i = 1'b0; imem_rdata_i = '0;
    redirect_i = 1'b0; redirect_pc_i = '0; stall_i = 1'b0;
    @(posedge clk); @(posedge clk); @(negedge clk);
    chk("rst_req", {31'b0, imem_req_o}, 32'h0);
    chk("rst_valid", {31'b0, if_valid_o}, 32'h0);
    chk("rst_instr", instr_o, NOP_INSTR);
    chk("rst_pc", pc_o, 32'h0);
    chk("rst_npc", npc_o, 32'h4);
    m_fifo.delete(); m_out.delete(); mem_q.delete();
    m_fetch = 32'h0; m_rsp = 32'h0;
    rst_i = 1'b0;
  endtask

  task automatic step(input bit g, input bit rd, input logic [31:0] t, input bit st);
    bit          rv_now, e_req, pop_m, stale;
    logic [31:0] d;
    imem_gnt_i = g; redirect_i = rd; redirect_pc_i = t; stall_i = st;
    rv_now = (mem_q.size() > 0) && (mem_q[0].due <= cyc);
    d = rv_now ? mem_q[0].data : 32'hDEAD_BEEF;
    imem_rvalid_i = rv_now; imem_rdata_i = d;
    #1;
    e_req = !rd && (m_fifo.size() + m_out.size() < 4);
    chk("req", {31'b0, imem_req_o}, {31'b0, e_req});
    if (e_req) chk("addr", imem_addr_o, m_fetch);
    chk("valid", {31'b0, if_valid_o}, {31'b0, m_fifo.size() != 0});
    if (m_fifo.size() != 0) begin
      chk("pc", pc_o, m_fifo[0].pc);
      chk("instr", instr_o, m_fifo[0].instr);
      chk("npc", npc_o, m_fifo[0].pc + 32'd4);
    end else begin
      chk("instr_nop", instr_o, NOP_INSTR);
    end
    if (rv_now) void'(mem_q.pop_front());
    if (imem_req_o && g) mem_q.push_back('{cyc + lat, imem_addr_o});
    pop_m = (m_fifo.size() != 0) && !st;
    if (rd) begin
      m_fifo.delete();
      if (rv_now && m_out.size() > 0) void'(m_out.pop_front());
      foreach (m_out[i]) m_out[i] = 1'b1;
      m_fetch = t & 32'hFFFF_FFFC;
      m_rsp   = t & 32'hFFFF_FFFC;
    end else begin
      if (pop_m) void'(m_fifo.pop_front());
      if (rv_now && m_out.size() > 0) begin
        stale = m_out.pop_front();
        if (!stale) begin
          m_fifo.push_back('{m_rsp, d});
          m_rsp = m_rsp + 32'd4;
        end
      end
      if (e_req && g) begin
        m_out.push_back(1'b0);
        m_fetch = m_fetch + 32'd4;
      end
    end
    @(posedge clk); cyc++; @(negedge clk);
  endtask

  task automatic run_until_valid(input string name, input logic [31:0] exp_pc);
    int k;
    for (k = 0; k < 12 && !if_valid_o; k++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk({name, "_valid"}, {31'b0, if_valid_o}, 32'h1);
    chk({name, "_pc"}, pc_o, exp_pc);
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1);
  end

  initial begin
    vec_t        tv[12];
    logic [31:0] pc0;

    // Redirect to 0x102 with two responses in flight, stall across the redirect.
    tv[0]  = mk(1, 0, 32'h0,   0, 32'h0,   0, 1, 32'h0,   0, 32'h0);
    tv[1]  = mk(1, 1, 32'h0,   0, 32'h0,   0, 1, 32'h4,   0, 32'h0);
    tv[2]  = mk(1, 1, 32'h4,   0, 32'h0,   0, 1, 32'h8,   1, 32'h0);
    tv[3]  = mk(1, 0, 32'h0,   0, 32'h0,   1, 1, 32'hC,   1, 32'h4);
    tv[4]  = mk(1, 1, 32'h8,   0, 32'h0,   1, 1, 32'h10,  1, 32'h4);
    tv[5]  = mk(1, 0, 32'h0,   1, 32'h102, 1, 0, 32'h0,   1, 32'h4);
    tv[6]  = mk(0, 1, 32'hC,   0, 32'h0,   0, 1, 32'h100, 0, 32'h0);
    tv[7]  = mk(1, 1, 32'h10,  0, 32'h0,   0, 1, 32'h100, 0, 32'h0);
    tv[8]  = mk(1, 1, 32'h100, 0, 32'h0,   0, 1, 32'h104, 0, 32'h0);
    tv[9]  = mk(0, 1, 32'h104, 0, 32'h0,   0, 1, 32'h108, 1, 32'h100);
    tv[10] = mk(0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h108, 1, 32'h104);
    tv[11] = mk(0, 0, 32'h0,   0, 32'h0,   0, 1, 32'h108, 0, 32'h0);

    do_reset();
    for (int i = 0; i < 12; i++) begin
      imem_gnt_i = tv[i].gnt; imem_rvalid_i = tv[i].rv; imem_rdata_i = tv[i].rdata;
      redirect_i = tv[i].redir; redirect_pc_i = tv[i].tgt; stall_i = tv[i].stall;
      #1;
      chk($sformatf("tv%0d_req", i), {31'b0, imem_req_o}, {31'b0, tv[i].e_req});
      if (tv[i].e_req) chk($sformatf("tv%0d_addr", i), imem_addr_o, tv[i].e_addr);
      chk($sformatf("tv%0d_valid", i), {31'b0, if_valid_o}, {31'b0, tv[i].e_valid});
      if (tv[i].e_valid) begin
        chk($sformatf("tv%0d_pc", i), pc_o, tv[i].e_pc);
        chk($sformatf("tv%0d_instr", i), instr_o, tv[i].e_pc);
        chk($sformatf("tv%0d_npc", i), npc_o, tv[i].e_pc + 32'd4);
      end else begin
        chk($sformatf("tv%0d_nop", i), instr_o, NOP_INSTR);
      end
      @(posedge clk); @(negedge clk);
    end

    // Streaming, then a 5-cycle stall and release.
    do_reset();
    lat = 1;
    for (int i = 0; i < 6; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    pc0 = pc_o;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b1);
    imem_gnt_i = 1'b1; stall_i = 1'b1; redirect_i = 1'b0; imem_rvalid_i = 1'b0;
    #1;
    chk("stall_credit_req", {31'b0, imem_req_o}, 32'h0);
    chk("stall_hold_pc", pc_o, pc0);
    for (int i = 0; i < 10; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

    // Redirect coinciding with a response while stalled (2-cycle memory).
    lat = 2;
    for (int i = 0; i < 5; i++) step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("redir_rv_present", {31'b0, mem_q.size() > 0 && mem_q[0].due <= cyc}, 32'h1);
    step(1'b1, 1'b1, 32'h0000_0041, 1'b1);
    chk("redir_empty", {31'b0, if_valid_o}, 32'h0);
    run_until_valid("redir_target", 32'h40);
    for (int i = 0; i < 8; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

    // Wrap-around at the top of the address space.
    lat = 1;
    step(1'b1, 1'b1, 32'hFFFF_FFFC, 1'b0);
    run_until_valid("wrap_first", 32'hFFFF_FFFC);
    chk("wrap_npc", npc_o, 32'h0);
    step(1'b1, 1'b0, 32'h0, 1'b0);
    chk("wrap_second_valid", {31'b0, if_valid_o}, 32'h1);
    chk("wrap_second_pc", pc_o, 32'h0);
    for (int i = 0; i < 4; i++) step(1'b1, 1'b0, 32'h0, 1'b0);

    // Randomized: 3-cycle memory, sparse grants, stalls, redirects, one reset.
    lat = 3;
    for (int i = 0; i < 1500; i++) begin
      if (i == 700) do_reset();
      step($urandom_range(0, 3) != 0, $urandom_range(0, 40) == 0, $urandom,
           $urandom_range(0, 3) == 0);
    end

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
